// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } state_t;
`endif

endpackage

// File: rtl/uart_rx_ctrl_bit_counter.sv
// Data-bit index counter: advances on enable_i and wraps to zero after max_i.
module rx_bit_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] count_o,
    output logic         atmax_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= atmax_o ? '0 : count_q + 1'b1;
        end
    end

    assign count_o = count_q;
    assign atmax_o = (count_q == max_i);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-entry output register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err_o port.
//
// Output handshake: data_o is consumed on a cycle where valid_o=1 and ready_i=1;
// valid_o then clears unless a new byte is delivered on that same cycle.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output state_t     state_o
);

    localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] FULL_LAST = 8'(CLKS_PER_BIT - 1);

    state_t                 state_q;
    logic                   sync1_q, sync2_q;
    logic [7:0]             tick_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [7:0]             data_q;
    logic                   valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   par_bad_q;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err_q;
`endif

    logic                   rx_s;
    logic                   half_hit, full_hit;
    logic                   bit_en, bit_atmax;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   deliver;

    assign rx_s     = sync2_q;
    assign half_hit = (tick_q == HALF_LAST);
    assign full_hit = (tick_q == FULL_LAST);
    assign bit_en   = (state_q == ST_DATA) && full_hit;
    assign deliver  = (state_q == ST_STOP) && full_hit && rx_s && !par_bad_q;

    rx_bit_counter #(
        .W(BIT_CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable_i(bit_en),
        .max_i   (BIT_CNT_W'(DATA_BITS - 1)),
        .count_o (bit_cnt),
        .atmax_o (bit_atmax)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            tick_q       <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            par_bad_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= rx_i;
            sync2_q     <= sync1_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif

            case (state_q)
                ST_IDLE: begin
                    tick_q    <= '0;
                    par_bad_q <= 1'b0;
                    if (!rx_s) state_q <= ST_START;
                end
                ST_START: begin
                    if (half_hit) begin
                        tick_q  <= '0;
                        state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_q <= tick_q + 8'd1;
                    end
                end
                ST_DATA: begin
                    if (full_hit) begin
                        tick_q           <= '0;
                        shift_q[bit_cnt] <= rx_s;
                        if (bit_atmax) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        tick_q <= tick_q + 8'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (full_hit) begin
                        tick_q  <= '0;
                        state_q <= ST_STOP;
                        if (rx_s != ^shift_q) begin
                            parity_err_q <= 1'b1;
                            par_bad_q    <= 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + 8'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (full_hit) begin
                        tick_q  <= '0;
                        state_q <= ST_IDLE;
                        if (!rx_s) frame_err_q <= 1'b1;
                    end else begin
                        tick_q <= tick_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tick_q  <= '0;
                end
            endcase

            // A delivery on a handshake cycle replaces the consumed byte.
            if (deliver) begin
                if (!valid_q || ready_i) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign state_o     = state_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl at CLKS_PER_BIT=16: vector table plus corner sequences.
// Parity sequences are compiled in only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;
    state_t     state_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
    int         perr_cnt = 0;
`endif

    uart_rx_ctrl #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_i),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err_o),
`endif
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int vcyc_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (valid_o)     vcyc_cnt++;
            if (frame_err_o) ferr_cnt++;
            if (overrun_o)   ovr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err_o) perr_cnt++;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rx_i = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask
`endif

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 200) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 32'(busy_o), 32'd0);
        repeat (4) tick();
    endtask

    task automatic drain(input string name);
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({name, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ready;
        int         exp_acc;
        int         exp_ferr;
        int         exp_ovr;
        int         exp_vcyc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int f0, o0, v0;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, ready: 1'b1, exp_acc: 1, exp_ferr: 0, exp_ovr: 0, exp_vcyc: 1};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, ready: 1'b1, exp_acc: 0, exp_ferr: 1, exp_ovr: 0, exp_vcyc: 0};
        vecs[2] = '{data: 8'h00, stop: 1'b1, ready: 1'b1, exp_acc: 1, exp_ferr: 0, exp_ovr: 0, exp_vcyc: 1};
        vecs[3] = '{data: 8'hFF, stop: 1'b1, ready: 1'b1, exp_acc: 1, exp_ferr: 0, exp_ovr: 0, exp_vcyc: 1};
        vecs[4] = '{data: 8'h81, stop: 1'b1, ready: 1'b1, exp_acc: 1, exp_ferr: 0, exp_ovr: 0, exp_vcyc: 1};

        rst_n   = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        repeat (3) tick();
        check("rst_data",  32'(data_o),      32'h00);
        check("rst_valid", 32'(valid_o),     32'd0);
        check("rst_ferr",  32'(frame_err_o), 32'd0);
        check("rst_ovr",   32'(overrun_o),   32'd0);
        check("rst_busy",  32'(busy_o),      32'd0);
        check("rst_state", 32'(state_o),     32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (4) tick();

        // Table of single frames.
        for (int i = 0; i < 5; i++) begin
            f0 = ferr_cnt; o0 = ovr_cnt; v0 = vcyc_cnt;
            ready_i = vecs[i].ready;
            if (vecs[i].exp_acc != 0) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            wait_idle($sformatf("vec%0d", i));
            drain($sformatf("vec%0d_acc", i));
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_ovr", i),  32'(ovr_cnt - o0),  32'(vecs[i].exp_ovr));
            check($sformatf("vec%0d_vcyc", i), 32'(vcyc_cnt - v0), 32'(vecs[i].exp_vcyc));
        end

        // Four-cycle low glitch: START sees the line high again at mid-bit.
        f0 = ferr_cnt; v0 = vcyc_cnt;
        rx_i = 1'b0;
        repeat (4) tick();
        rx_i = 1'b1;
        tick();
        check("glitch_busy_hi", 32'(busy_o), 32'd1);
        repeat (7) tick();
        check("glitch_busy_lo", 32'(busy_o),         32'd0);
        check("glitch_valid",   32'(valid_o),        32'd0);
        check("glitch_ferr",    32'(ferr_cnt - f0),  32'd0);
        check("glitch_vcyc",    32'(vcyc_cnt - v0),  32'd0);
        repeat (8) tick();

        // Overrun: second byte dropped while the first is held.
        o0 = ovr_cnt;
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1);
        wait_idle("ovr_a");
        check("ovr_a_valid", 32'(valid_o), 32'd1);
        check("ovr_a_data",  32'(data_o),  32'h11);
        send_frame(8'h22, 1'b1);
        wait_idle("ovr_b");
        check("ovr_b_pulse", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_b_data",  32'(data_o),       32'h11);
        check("ovr_b_valid", 32'(valid_o),      32'd1);
        exp_q.push_back(8'h11);
        ready_i = 1'b1;
        repeat (3) tick();
        check("ovr_clear", 32'(valid_o), 32'd0);
        drain("ovr_acc");

        // Reset during the 4th data bit of 0xFF, then a clean 0x5A.
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        repeat (CPB / 2) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        check("mid_rst_data",  32'(data_o),  32'h00);
        check("mid_rst_busy",  32'(busy_o),  32'd0);
        check("mid_rst_state", 32'(state_o), 32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (CPB * 6) tick();
        check("post_rst_busy",  32'(busy_o),  32'd0);
        check("post_rst_valid", 32'(valid_o), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_idle("rst_5a");
        drain("rst_5a_acc");
        check("rst_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("rst_ovr",  32'(ovr_cnt - o0),  32'd0);

`ifdef UART_RX_PARITY_EN
        begin
            int p0;
            p0 = perr_cnt;
            send_frame_par(8'h07, 1'b0);
            wait_idle("par_bad");
            check("par_bad_pulse", 32'(perr_cnt - p0), 32'd1);
            drain("par_bad_acc");
            p0 = perr_cnt;
            exp_q.push_back(8'h07);
            send_frame_par(8'h07, 1'b1);
            wait_idle("par_good");
            check("par_good_pulse", 32'(perr_cnt - p0), 32'd0);
            drain("par_good_acc");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
